line_clear_ctrl: RTL

Sequences the board row memory after a tetromino locks. Scans rows bottom-up, detects full rows, compacts the surviving rows downward, and fills the vacated top rows with EMPTY. Holds board_busy high throughout so block movement and spawning are frozen. Reports per-lock and running line counts to the score and level logic.

---
 rtl/line_clear_ctrl_pkg.sv | 29 ++
 rtl/line_clear_ctrl_row_full_detect.sv | 21 ++
 rtl/line_clear_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/line_clear_ctrl_pkg.sv
// Shared game types: cell colours, board geometry, line-clear FSM states.
// Imported by the board sequencing logic and the row checks.
package line_clear_ctrl_pkg;

  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;
  localparam int CELL_BITS  = 3;
  localparam int MAX_CLEAR  = 4;

  typedef enum logic [CELL_BITS-1:0] {
    EMPTY  = 3'd0,
    CYAN   = 3'd1,
    YELLOW = 3'd2,
    PURPLE = 3'd3,
    GREEN  = 3'd4,
    RED    = 3'd5,
    BLUE   = 3'd6,
    ORANGE = 3'd7
  } block_color_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    FILL,
    DONE
  } lc_state_t;

endpackage

// File: rtl/line_clear_ctrl_row_full_detect.sv
// Combinational full-row test: every cell of the row is non-EMPTY.
// Ports: row (COLS*CELL_W packed cells), full (1 = no empty cell).
module row_full_detect
  import line_clear_ctrl_pkg::*;
#(
  parameter int COLS   = BOARD_COLS,
  parameter int CELL_W = CELL_BITS
) (
  input  logic [COLS*CELL_W-1:0] row,
  output logic                   full
);

  always_comb begin
    full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (row[c*CELL_W +: CELL_W] == CELL_W'(EMPTY))
        full = 1'b0;
    end
  end

endmodule

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans rows bottom-up, compacts survivors, zero-fills top.
// Ports: Clk/Reset, lock_req in; row memory rd/wr ports; busy, done, line counts out.
module line_clear_ctrl
  import line_clear_ctrl_pkg::*;
#(
  parameter int COLS    = BOARD_COLS,
  parameter int ROWS    = BOARD_ROWS,
  parameter int CELL_W  = CELL_BITS,
  parameter int ROW_W   = 5,
  parameter int TOTAL_W = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   lock_req,
  output logic [ROW_W-1:0]       row_rd_addr,
  input  logic [COLS*CELL_W-1:0] row_rd_data,
  output logic                   row_wr_en,
  output logic [ROW_W-1:0]       row_wr_addr,
  output logic [COLS*CELL_W-1:0] row_wr_data,
  output logic                   board_busy,
  output logic                   done,
  output logic [2:0]             lines_cleared,
  output logic [TOTAL_W-1:0]     lines_total
);

  localparam logic [ROW_W-1:0] LAST = ROW_W'(ROWS - 1);

  lc_state_t state, state_n;
  logic [ROW_W-1:0] r, r_n;
  logic [ROW_W-1:0] w, w_n;
  logic [ROW_W-1:0] cnt, cnt_n;
  logic [ROW_W-1:0] fill_row, fill_n;
  logic pending, pend_n;
  logic [2:0] lc_n;
  logic [TOTAL_W-1:0] lt_n;
  logic [TOTAL_W:0] sum;
  logic full;

  row_full_detect #(
    .COLS   (COLS),
    .CELL_W (CELL_W)
  ) u_full (
    .row  (row_rd_data),
    .full (full)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      r             <= '0;
      w             <= '0;
      cnt           <= '0;
      fill_row      <= '0;
      pending       <= 1'b0;
      lines_cleared <= '0;
      lines_total   <= '0;
    end else begin
      state         <= state_n;
      r             <= r_n;
      w             <= w_n;
      cnt           <= cnt_n;
      fill_row      <= fill_n;
      pending       <= pend_n;
      lines_cleared <= lc_n;
      lines_total   <= lt_n;
    end
  end

  always_comb begin
    state_n     = state;
    r_n         = r;
    w_n         = w;
    cnt_n       = cnt;
    fill_n      = fill_row;
    pend_n      = pending;
    lc_n        = lines_cleared;
    lt_n        = lines_total;
    sum         = '0;
    row_rd_addr = '0;
    row_wr_en   = 1'b0;
    row_wr_addr = '0;
    row_wr_data = '0;
    board_busy  = 1'b0;
    done        = 1'b0;

    // Locks arriving while the board is owned collapse into one rerun.
    if (lock_req && state != IDLE)
      pend_n = 1'b1;

    unique case (state)
      IDLE: begin
        if (lock_req) begin
          r_n     = LAST;
          w_n     = LAST;
          cnt_n   = '0;
          fill_n  = '0;
          state_n = READ;
        end
      end
      READ: begin
        board_busy  = 1'b1;
        row_rd_addr = r;
        state_n     = CHECK;
      end
      CHECK: begin
        board_busy = 1'b1;
        if (full) begin
          cnt_n = cnt + 1'b1;
        end else begin
          // Survivor already in place needs no rewrite.
          if (w != r) begin
            row_wr_en   = 1'b1;
            row_wr_addr = w;
            row_wr_data = row_rd_data;
          end
          w_n = w - 1'b1;
        end
        if (r == '0) begin
          state_n = (cnt_n != '0) ? FILL : DONE;
        end else begin
          r_n     = r - 1'b1;
          state_n = READ;
        end
      end
      FILL: begin
        board_busy  = 1'b1;
        row_wr_en   = 1'b1;
        row_wr_addr = fill_row;
        fill_n      = fill_row + 1'b1;
        if (fill_row == cnt - 1'b1)
          state_n = DONE;
      end
      DONE: begin
        done = 1'b1;
        lc_n = (cnt > ROW_W'(MAX_CLEAR)) ? 3'd4 : cnt[2:0];
        sum  = {1'b0, lines_total} + (TOTAL_W+1)'(cnt);
        lt_n = sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
        if (pending || lock_req) begin
          pend_n  = 1'b0;
          r_n     = LAST;
          w_n     = LAST;
          cnt_n   = '0;
          fill_n  = '0;
          state_n = READ;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
